seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Parametrised multiplexed seven-segment display driver. It latches an N-digit hex value with per-digit decimal points and scans it onto a shared segment bus with one-hot digit enables. Hex decode is standard 0–F, with optional leading-zero blanking, anti-ghosting dead time and tear-free frame-synchronous updates. It sits between the board-level display pins and any user logic that wants to show a number.

## Interface
- DIGITS, 4: number of multiplexed digits, 1..8
- DIV, 1000: clock cycles per digit slot, ≥ 2
- ACTIVE_LOW, 1: 1 means `seg`, `dp` and `an` are driven active-low; 0 means active-high

Ports:
- clk  in  1  system clock
- rst  in  1  reset (one clock; reset is synchronous and active-high)
- load  in  1  capture strobe for `value`, `dp_in` and `lz_en`
- value  in  4*DIGITS  hex nibbles; nibble i is shown on digit i, and digit 0 is the rightmost
- dp_in  in  DIGITS  decimal point per digit
- lz_en  in  1  leading-zero blanking enable
- seg  out  7  segments, bit0 = a … bit6 = g
- dp  out  1  decimal point of the active digit
- an  out  DIGITS  digit enables, one-hot or none
- frame  out  1  one-cycle pulse at scan wrap (commit point)
- pending  out  1  a loaded value is waiting for commit

## Operation
- **Pending register.** `load` copies `value`, `dp_in` and `lz_en` into the pending register and sets `pend_valid`. A later `load` before commit overwrites it; the last one wins.
- **Prescaler.** `cnt` counts 0..DIV-1. At `cnt==DIV-1`, the slot ends and `idx` advances modulo DIGITS.
- **Commit.** Commit happens on the slot end where `idx` wraps DIGITS-1→0. On that cycle `frame`=1. If `pend_valid` is set, pending moves to the display register and `pend_valid` clears. A `load` in the same cycle as a commit is committed directly, so `pend_valid` stays 0.
- **Blank mask.** The blank mask is computed at commit. With lz_en=1, digit i is blanked when all nibbles i..DIGITS-1 are 0. Digit 0 is never blanked. The decimal point of a blanked digit is also suppressed.
- **Active digit.** The active digit drives the decoded nibble on `seg` and its dp bit on `dp`, with `an[idx]` asserted. A blanked digit drives all segments off and keeps `an` asserted.
- **Dead time.** During `cnt==DIV-1`, all `an` are inactive.
- **Polarity.** Every output passes through the ACTIVE_LOW polarity inversion, and is registered.

## Timing
- **Reset.** cnt=0, idx=0, display register=0, blank mask=0, pend_valid=0, `pending`=0, `frame`=0. `seg`, `dp` and `an` are inactive: all 1 when ACTIVE_LOW=1.
- **First valid output.** The first cycle after `rst` falls shows digit 0 of the display register, which is 0.
- **Output latency.** Outputs reflect `cnt`/`idx`/display state with one cycle latency. `frame` is registered and aligned with the first output cycle of digit 0 of the new frame.
- **Pending latency.** `pending` goes high the cycle after `load`.
- **Worst-case load→visible.** DIGITS*DIV+1 cycles.
- **Reset mid-scan.** Reset discards pending data and the display returns to 0 immediately on the next edge. `load` asserted with `rst` is ignored.
- **DIGITS=1.** Every slot end is a wrap, so `frame` fires every DIV cycles.

## Structure
- **Package `seven_seg_pkg`:**
  - segment bit index constants (SEG_A..SEG_G)
  - the 16-entry hex→segment constant table, active-high
  - the `seg_t` 7-bit typedef
- **Sub-module `seven_seg_hex`:** pure combinational nibble→`seg_t` decode using the table. It is instantiated once, on the muxed nibble.
- **Top:** prescaler, scan index, pending and display registers, blank-mask logic, output polarity registers.

## Test plan
(DIGITS=4, DIV=4, ACTIVE_LOW=1 unless stated.)
- **Reset.** Hold rst 3 cycles → seg=7'h7F, an=4'hF, dp=1, pending=0. Release → first cycle shows an=4'hE, seg=7'h40 ("0").
- **Static scan.** load value=16'h12AF, dp_in=4'b0100, lz_en=0 → after the next frame pulse the repeating pattern is:
  - an: E,E,E,F / D,D,D,F / B,B,B,F / 7,7,7,F
  - seg: F=0x0E, A=0x08, 2=0x24, 1=0x79
  - dp=0 only while an=B
- **Leading-zero blanking.** load value=16'h0050, lz_en=1 → digits 3 and 2 drive seg=7'h7F with an asserted; digit 1 shows "5" (0x12); digit 0 shows "0".
- **Tear-free update.** load 16'h1111 mid-frame, then 16'h2222 one cycle later, before the wrap:
  - pending=1 until the frame pulse
  - no slot ever shows "2" before frame=1
  - "1111" is never displayed
- **Load on commit cycle.** Assert load exactly on the wrap cycle with value 16'h3333 → new frame shows "3333" and pending stays 0.
- **Reset mid-frame and polarity.**
  - ACTIVE_LOW=1: rst during digit 2 with pending set → next cycle all outputs inactive and pending=0; after release the display is "0000".
  - ACTIVE_LOW=0: the same sequence drives all-zero inactive outputs.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared types and constants for the multiplexed seven-segment
//                display driver: segment bit indices, the seg_t bus type and
//                the active-high hex-to-segment table.
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    // One bit per segment, bit0 = a ... bit6 = g.
    typedef logic [6:0] seg_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high glyphs for 0..F (lower-case b and d so they differ from 8/0).
    localparam seg_t c_hex_table [16] = '{
        7'h3F,  // 0 : a b c d e f
        7'h06,  // 1 : b c
        7'h5B,  // 2 : a b d e g
        7'h4F,  // 3 : a b c d g
        7'h66,  // 4 : b c f g
        7'h6D,  // 5 : a c d f g
        7'h7D,  // 6 : a c d e f g
        7'h07,  // 7 : a b c
        7'h7F,  // 8 : all
        7'h6F,  // 9 : a b c d f g
        7'h77,  // A : a b c e f g
        7'h7C,  // b : c d e f g
        7'h39,  // C : a d e f
        7'h5E,  // d : b c d e g
        7'h79,  // E : a d e f g
        7'h71   // F : a e f g
    };

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_if
//  Description : Bundle between user logic and the display driver.
//                master : user side (drives load/value/dp_in/lz_en,
//                         observes the scan outputs)
//                slave  : display driver side
//                Ports  : load, value[4*DIGITS], dp_in[DIGITS], lz_en,
//                         seg[7], dp, an[DIGITS], frame, pending
//  Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_if
    import seven_seg_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  lz_en;
    seg_t                  seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame;
    logic                  pending;

    modport master (
        output load, value, dp_in, lz_en,
        input  seg, dp, an, frame, pending
    );

    modport slave (
        input  load, value, dp_in, lz_en,
        output seg, dp, an, frame, pending
    );

endinterface
`default_nettype wire

// File: rtl/seven_seg_hex.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_hex
//  Description : Combinational nibble to active-high segment decode.
//                Ports : i_nibble[4] in, o_seg[7] out (bit0 = a)
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_hex
    import seven_seg_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output seg_t            o_seg
);

    always_comb begin
        o_seg = c_hex_table[i_nibble];
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan
//  Description : Multiplexed N-digit seven-segment driver. Captures a hex
//                value into a pending register and commits it to the display
//                register only at the scan wrap, so a frame never tears.
//                Supports leading-zero blanking, a one-cycle dead time at the
//                end of every digit slot and selectable output polarity.
//                Ports : clk, rst (sync, active-high),
//                        bus (seven_seg_scan_if.slave):
//                          load, value, dp_in, lz_en  -> in
//                          seg, dp, an, frame, pending -> out
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIV        = 1000,
    parameter int ACTIVE_LOW = 1
)(
    input  wire logic          clk,
    input  wire logic          rst,
    seven_seg_scan_if.slave    bus
);

    localparam int c_cnt_w = $clog2(DIV);
    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // ------------------------------------------------------------------
    // Blank mask: digit i is dark when it and every digit to its left are
    // zero. Digit 0 is never blanked so a zero value still shows "0".
    // ------------------------------------------------------------------
    function automatic logic [DIGITS-1:0] blank_mask(
        input logic [4*DIGITS-1:0] val,
        input logic                lz
    );
        logic [DIGITS-1:0] m;
        logic              all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (val[4*i +: 4] == 4'h0);
            m[i]     = lz & all_zero;
        end
        return m;
    endfunction

    // Scan state
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_idx;

    // Pending (staging) and display registers
    logic [4*DIGITS-1:0]  r_pend_val;
    logic [DIGITS-1:0]    r_pend_dp;
    logic                 r_pend_lz;
    logic                 r_pend_valid;
    logic [4*DIGITS-1:0]  r_disp_val;
    logic [DIGITS-1:0]    r_disp_dp;
    logic [DIGITS-1:0]    r_blank;

    // Output registers (already polarity adjusted)
    seg_t                 r_seg;
    logic                 r_dp;
    logic [DIGITS-1:0]    r_an;
    logic                 r_commit_d;
    logic                 r_frame;

    logic                 w_slot_end;
    logic                 w_wrap;
    logic                 w_do_commit;
    logic [4*DIGITS-1:0]  w_src_val;
    logic [DIGITS-1:0]    w_src_dp;
    logic                 w_src_lz;
    logic [3:0]           w_nibble;
    seg_t                 w_hex_seg;
    seg_t                 w_seg_ah;
    logic                 w_dp_ah;
    logic [DIGITS-1:0]    w_an_ah;
    seg_t                 w_seg_pol;
    logic                 w_dp_pol;
    logic [DIGITS-1:0]    w_an_pol;
    seg_t                 w_seg_idle;
    logic                 w_dp_idle;
    logic [DIGITS-1:0]    w_an_idle;

    assign w_slot_end = (r_cnt == c_cnt_w'(DIV - 1));
    assign w_wrap     = w_slot_end && (r_idx == c_idx_w'(DIGITS - 1));

    // A load coinciding with the wrap bypasses the pending register so the
    // newest value is what the next frame shows.
    assign w_src_val   = bus.load ? bus.value : r_pend_val;
    assign w_src_dp    = bus.load ? bus.dp_in : r_pend_dp;
    assign w_src_lz    = bus.load ? bus.lz_en : r_pend_lz;
    assign w_do_commit = w_wrap && (bus.load || r_pend_valid);

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= w_wrap ? '0 : r_idx + c_idx_w'(1);
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Pending register: last load before the wrap wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_lz    <= 1'b0;
            r_pend_valid <= 1'b0;
        end else if (w_wrap) begin
            r_pend_valid <= 1'b0;
        end else if (bus.load) begin
            r_pend_val   <= bus.value;
            r_pend_dp    <= bus.dp_in;
            r_pend_lz    <= bus.lz_en;
            r_pend_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Display register and blank mask, updated only at the commit point.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_blank    <= '0;
        end else if (w_do_commit) begin
            r_disp_val <= w_src_val;
            r_disp_dp  <= w_src_dp;
            r_blank    <= blank_mask(w_src_val, w_src_lz);
        end
    end

    // ------------------------------------------------------------------
    // Active-digit selection and decode (single shared decoder)
    // ------------------------------------------------------------------
    assign w_nibble = r_disp_val[{r_idx, 2'b00} +: 4];

    seven_seg_hex u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_hex_seg)
    );

    // The last cycle of each slot turns everything off so the segment bus
    // can change without ghosting onto the neighbouring digit.
    always_comb begin
        w_seg_ah = w_hex_seg;
        w_dp_ah  = r_disp_dp[r_idx];
        w_an_ah  = DIGITS'(1) << r_idx;
        if (w_slot_end) begin
            w_seg_ah = '0;
            w_dp_ah  = 1'b0;
            w_an_ah  = '0;
        end else if (r_blank[r_idx]) begin
            w_seg_ah = '0;
            w_dp_ah  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output polarity
    // ------------------------------------------------------------------
    if (ACTIVE_LOW != 0) begin : g_active_low
        assign w_seg_pol  = ~w_seg_ah;
        assign w_dp_pol   = ~w_dp_ah;
        assign w_an_pol   = ~w_an_ah;
        assign w_seg_idle = '1;
        assign w_dp_idle  = 1'b1;
        assign w_an_idle  = '1;
    end else begin : g_active_high
        assign w_seg_pol  = w_seg_ah;
        assign w_dp_pol   = w_dp_ah;
        assign w_an_pol   = w_an_ah;
        assign w_seg_idle = '0;
        assign w_dp_idle  = 1'b0;
        assign w_an_idle  = '0;
    end

    // frame is delayed twice from the wrap so it lines up with the first
    // registered output of digit 0 in the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg      <= w_seg_idle;
            r_dp       <= w_dp_idle;
            r_an       <= w_an_idle;
            r_commit_d <= 1'b0;
            r_frame    <= 1'b0;
        end else begin
            r_seg      <= w_seg_pol;
            r_dp       <= w_dp_pol;
            r_an       <= w_an_pol;
            r_commit_d <= w_wrap;
            r_frame    <= r_commit_d;
        end
    end

    assign bus.seg     = r_seg;
    assign bus.dp      = r_dp;
    assign bus.an      = r_an;
    assign bus.frame   = r_frame;
    assign bus.pending = r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan
//  Description : Self-checking bench. Two drivers (active-low and active-high)
//                share one stimulus stream; a cycle-count based display model
//                predicts every output each cycle, and scripted scenarios pin
//                literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int FR = N * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scan_if #(.DIGITS(N)) bus_al ();
    seven_seg_scan_if #(.DIGITS(N)) bus_ah ();

    assign bus_ah.load  = bus_al.load;
    assign bus_ah.value = bus_al.value;
    assign bus_ah.dp_in = bus_al.dp_in;
    assign bus_ah.lz_en = bus_al.lz_en;

    seven_seg_scan #(.DIGITS(N), .DIV(D), .ACTIVE_LOW(1)) dut_al (
        .clk (clk), .rst (rst), .bus (bus_al)
    );
    seven_seg_scan #(.DIGITS(N), .DIV(D), .ACTIVE_LOW(0)) dut_ah (
        .clk (clk), .rst (rst), .bus (bus_ah)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Glyphs described by their lit segment letters.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        string      s;
        logic [6:0] r;
        case (n)
            4'h0: s = "abcdef";   4'h1: s = "bc";
            4'h2: s = "abdeg";    4'h3: s = "abcdg";
            4'h4: s = "bcfg";     4'h5: s = "acdfg";
            4'h6: s = "acdefg";   4'h7: s = "abc";
            4'h8: s = "abcdefg";  4'h9: s = "abcdfg";
            4'hA: s = "abcefg";   4'hB: s = "cdefg";
            4'hC: s = "adef";     4'hD: s = "bcdeg";
            4'hE: s = "adefg";    default: s = "aefg";
        endcase
        r = '0;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    function automatic bit blanked(input logic [4*N-1:0] v, input logic lz, input int d);
        if (!lz || d == 0) return 1'b0;
        return (v >> (4 * d)) == 0;
    endfunction

    // ------------------------------------------------------------------
    // Model: t counts clocks since reset; slot, digit and commit points are
    // plain arithmetic on t. Expectations are active-high.
    // ------------------------------------------------------------------
    bit              model_ok = 1'b0;
    int              t, pos, dg;
    logic [4*N-1:0]  m_val, p_val;
    logic [N-1:0]    m_dp, p_dp;
    logic            m_lz, p_lz, p_v;
    logic [6:0]      e_seg;
    logic            e_dp, e_frame, e_pending;
    logic [N-1:0]    e_an;

    initial begin
        logic [6:0]   xs;
        logic [N-1:0] xa;
        logic         xd;
        forever begin
            @(negedge clk);
            if (model_ok) begin
                xs = ~e_seg; xa = ~e_an; xd = ~e_dp;
                check("al_seg", bus_al.seg, xs);
                check("al_an", bus_al.an, xa);
                check("al_dp", bus_al.dp, xd);
                check("al_frame", bus_al.frame, e_frame);
                check("al_pending", bus_al.pending, e_pending);
                check("ah_seg", bus_ah.seg, e_seg);
                check("ah_an", bus_ah.an, e_an);
                check("ah_dp", bus_ah.dp, e_dp);
                check("ah_frame", bus_ah.frame, e_frame);
                check("ah_pending", bus_ah.pending, e_pending);
            end
            // Predict the outputs of the coming rising edge from current inputs.
            if (rst) begin
                t = 0; m_val = '0; m_dp = '0; m_lz = 1'b0; p_v = 1'b0;
                e_seg = '0; e_dp = 1'b0; e_an = '0; e_frame = 1'b0; e_pending = 1'b0;
                model_ok = 1'b1;
            end else begin
                pos = t % D;
                dg  = (t / D) % N;
                e_frame = (t > 0) && (t % FR == 0);
                if (pos == D - 1 || blanked(m_val, m_lz, dg)) begin
                    e_seg = '0; e_dp = 1'b0;
                end else begin
                    e_seg = seg_of(m_val[4*dg +: 4]);
                    e_dp  = m_dp[dg];
                end
                e_an = (pos == D - 1) ? '0 : (N'(1) << dg);
                if (t % FR == FR - 1) begin
                    if (bus_al.load) begin
                        m_val = bus_al.value; m_dp = bus_al.dp_in; m_lz = bus_al.lz_en;
                    end else if (p_v) begin
                        m_val = p_val; m_dp = p_dp; m_lz = p_lz;
                    end
                    p_v = 1'b0;
                end else if (bus_al.load) begin
                    p_val = bus_al.value; p_dp = bus_al.dp_in; p_lz = bus_al.lz_en; p_v = 1'b1;
                end
                e_pending = p_v;
                t++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: all driving happens 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
        bus_al.load  = 1'b1;
        bus_al.value = v;
        bus_al.dp_in = d;
        bus_al.lz_en = lz;
        tick();
        bus_al.load  = 1'b0;
    endtask

    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            tick();
            if (bus_al.frame === 1'b1) found = 1'b1;
        end
        check("frame_timeout", found, 1'b1);
    endtask

    logic [3:0] an_seq  [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
    logic [6:0] scan_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    logic [6:0] lz_seg   [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};

    initial begin
        bus_al.load  = 1'b0;
        bus_al.value = '0;
        bus_al.dp_in = '0;
        bus_al.lz_en = 1'b0;
        rst = 1'b1;

        // Reset
        repeat (3) tick();
        check("rst_seg", bus_al.seg, 7'h7F);
        check("rst_an", bus_al.an, 4'hF);
        check("rst_dp", bus_al.dp, 1'b1);
        check("rst_pending", bus_al.pending, 1'b0);
        rst = 1'b0;
        tick();
        check("first_an", bus_al.an, 4'hE);
        check("first_seg", bus_al.seg, 7'h40);

        // Static scan
        repeat (3) tick();
        do_load(16'h12AF, 4'b0100, 1'b0);
        wait_frame();
        for (int k = 0; k < 16; k++) begin
            check("scan_an", bus_al.an, an_seq[k]);
            check("scan_dp", bus_al.dp, (k >= 8 && k <= 10) ? 1'b0 : 1'b1);
            if (an_seq[k] != 4'hF) check("scan_seg", bus_al.seg, scan_seg[k / 4]);
            tick();
        end

        // Leading-zero blanking
        do_load(16'h0050, 4'b1111, 1'b1);
        wait_frame();
        for (int k = 0; k < 16; k++) begin
            if (an_seq[k] != 4'hF) begin
                check("lz_seg", bus_al.seg, lz_seg[k / 4]);
                check("lz_an", bus_al.an, an_seq[k]);
            end
            tick();
        end

        // Tear-free update
        wait_frame();
        repeat (5) tick();
        do_load(16'h1111, 4'h0, 1'b0);
        do_load(16'h2222, 4'h0, 1'b0);
        check("tear_pending", bus_al.pending, 1'b1);
        wait_frame();
        check("tear_seg", bus_al.seg, 7'h24);
        check("tear_pending_clr", bus_al.pending, 1'b0);

        // Load on the commit cycle
        wait_frame();
        repeat (14) tick();
        do_load(16'h3333, 4'h0, 1'b0);
        check("commit_pending", bus_al.pending, 1'b0);
        tick();
        check("commit_frame", bus_al.frame, 1'b1);
        check("commit_seg", bus_al.seg, 7'h30);

        // Reset mid-frame with data pending
        wait_frame();
        repeat (9) tick();
        do_load(16'h5678, 4'h5, 1'b0);
        check("mid_pending", bus_al.pending, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_al_seg", bus_al.seg, 7'h7F);
        check("mid_al_an", bus_al.an, 4'hF);
        check("mid_al_dp", bus_al.dp, 1'b1);
        check("mid_ah_seg", bus_ah.seg, 7'h00);
        check("mid_ah_an", bus_ah.an, 4'h0);
        check("mid_ah_dp", bus_ah.dp, 1'b0);
        check("mid_pending_clr", bus_al.pending, 1'b0);
        rst = 1'b0;
        tick();
        check("mid_rel_al_seg", bus_al.seg, 7'h40);
        check("mid_rel_ah_seg", bus_ah.seg, 7'h3F);
        check("mid_rel_ah_an", bus_ah.an, 4'h1);
        wait_frame();
        check("mid_after_seg", bus_al.seg, 7'h40);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) rst = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                bus_al.load  = 1'b1;
                bus_al.value = 16'($urandom);
                bus_al.dp_in = 4'($urandom);
                bus_al.lz_en = 1'($urandom);
                if ($urandom_range(0, 3) == 0) bus_al.value[15:8] = 8'h00;
            end
            tick();
            bus_al.load = 1'b0;
            rst = 1'b0;
        end

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
